// File: rtl/z80_wb_bridge_pkg.sv
// Shared types and constants for the Z80-to-Wishbone bridge.
package z80_wb_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [7:0]  READ_ERR_DATA_DEFAULT = 8'hFF;
  localparam int unsigned CTL_WIDTH             = 3;

  // A memory cycle starts on MREQ plus RD or WR; MREQ alone is a refresh.
  function automatic logic cycle_start(input logic mreq_n, input logic rd_n, input logic wr_n);
    return !mreq_n && (!rd_n || !wr_n);
  endfunction

endpackage

// File: rtl/z80_wb_bridge_sync_2ff.sv
// Two-flop synchronizer for asynchronous Z80 control pins.
module z80_wb_bridge_sync_2ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z80_wb_bridge.sv
// Converts Z80 memory cycles into single pipelined Wishbone transactions,
// holding the CPU in WAIT until the slave acks or the transaction times out.
module z80_wb_bridge
  import z80_wb_bridge_pkg::*;
#(
  parameter int unsigned               CPU_DATA_WIDTH = 8,
  parameter int unsigned               CPU_ADDR_WIDTH = 16,
  parameter int unsigned               TIMEOUT_CYCLES = 255,
  parameter int unsigned               TIMEOUT_WIDTH  = 8,
  parameter logic [CPU_DATA_WIDTH-1:0] READ_ERR_DATA  = CPU_DATA_WIDTH'(READ_ERR_DATA_DEFAULT)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_z80_mreq_n,
  input  logic                      i_z80_rd_n,
  input  logic                      i_z80_wr_n,
  input  logic [CPU_ADDR_WIDTH-1:0] i_z80_addr,
  input  logic [CPU_DATA_WIDTH-1:0] i_z80_data,
  output logic [CPU_DATA_WIDTH-1:0] o_z80_data,
  output logic                      o_z80_data_oe,
  output logic                      o_z80_wait_n,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [CPU_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [CPU_DATA_WIDTH-1:0] o_wb_data,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_stall,
  input  logic [CPU_DATA_WIDTH-1:0] i_wb_data,
  output logic                      o_bus_error,
  input  logic                      i_err_clear
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CTL_WIDTH-1:0] ctl_sync;
  logic                 mreq_s;
  logic                 rd_s;
  logic                 wr_s;
  logic                 start_c;

  state_t                    state, state_d;
  logic [TIMEOUT_WIDTH-1:0]  cnt, cnt_d;
  logic                      cyc_d, stb_d, we_d, oe_d, wait_n_d, err_d;
  logic [CPU_ADDR_WIDTH-1:0] addr_d;
  logic [CPU_DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic                      timeout_c;
  logic                      finish_c;

  z80_wb_bridge_sync_2ff #(
    .WIDTH       (CTL_WIDTH),
    .RESET_VALUE ('1)
  ) u_sync (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     ({i_z80_mreq_n, i_z80_rd_n, i_z80_wr_n}),
    .q     (ctl_sync)
  );

  assign mreq_s  = ctl_sync[2];
  assign rd_s    = ctl_sync[1];
  assign wr_s    = ctl_sync[0];
  assign start_c = cycle_start(mreq_s, rd_s, wr_s);

  // Next-state and next-output decode; every output is a registered copy.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cyc_d     = o_wb_cyc;
    stb_d     = o_wb_stb;
    we_d      = o_wb_we;
    addr_d    = o_wb_addr;
    wdata_d   = o_wb_data;
    rdata_d   = o_z80_data;
    oe_d      = o_z80_data_oe;
    wait_n_d  = o_z80_wait_n;
    err_d     = o_bus_error;
    timeout_c = 1'b0;
    finish_c  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_c) begin
          addr_d   = i_z80_addr;
          we_d     = !wr_s;
          if (!wr_s) wdata_d = i_z80_data;
          wait_n_d = 1'b0;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_STROBE;
        end
      end
      S_STROBE, S_WAIT_ACK: begin
        if (i_wb_ack) begin
          if (!o_wb_we) rdata_d = i_wb_data;
          finish_c = 1'b1;
        end else if (cnt == CNT_LAST) begin
          if (!o_wb_we) rdata_d = READ_ERR_DATA;
          timeout_c = 1'b1;
          finish_c  = 1'b1;
        end else begin
          cnt_d = cnt + TIMEOUT_WIDTH'(1);
          if ((state == S_STROBE) && !i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_DONE: begin
        if (mreq_s) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish_c) begin
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      wait_n_d = 1'b1;
      oe_d     = !o_wb_we;
      state_d  = S_DONE;
    end

    if (timeout_c)        err_d = 1'b1;
    else if (i_err_clear) err_d = 1'b0;
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_z80_data    <= '0;
      o_z80_data_oe <= 1'b0;
      o_z80_wait_n  <= 1'b1;
      o_bus_error   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      o_wb_cyc      <= cyc_d;
      o_wb_stb      <= stb_d;
      o_wb_we       <= we_d;
      o_wb_addr     <= addr_d;
      o_wb_data     <= wdata_d;
      o_z80_data    <= rdata_d;
      o_z80_data_oe <= oe_d;
      o_z80_wait_n  <= wait_n_d;
      o_bus_error   <= err_d;
    end
  end

endmodule
